fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the single-cycle decode/execute datapath (control, aluctrl, regfile, alu).
- Owns the program counter and issues word addresses to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a small prefetch queue and hands them to decode over a valid/ready handshake.
- Accepts jump/branch redirects from control and flushes stale fetches.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle-latency imem interface, prefetch queue, redirect flush.
// Optional halt-on-all-ones-word support is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_valid,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   instr_ready,
    output logic                   halted
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] word;
        logic [PC_WIDTH-1:0]    pc;
    } entry_t;

    entry_t              queue_mem [QUEUE_DEPTH];
    entry_t              head;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic                inflight;
    logic                discard;
    logic                halt_q;
    logic                issue;
    logic                push;
    logic                pop;

    // Counting the in-flight request reserves its queue slot, so a response never overflows.
    // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
    always_comb begin
        issue = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        head  = queue_mem[rd_ptr];
        if (!rst && !redirect && !halt_q)
            issue = (count + CNT_W'(inflight)) < CNT_W'(QUEUE_DEPTH);
        push = imem_valid && inflight && !discard && !redirect && !rst;
        pop  = instr_valid && instr_ready;
    end

    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign instr_valid = (count != '0) && !redirect;
    assign instr       = (count != '0) ? head.word : '0;
    assign instr_pc    = (count != '0) ? head.pc   : '0;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            discard     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            discard  <= inflight;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            discard  <= 1'b0;
            inflight <= issue;
            if (issue) begin
                pc          <= pc + PC_WIDTH'(1);
                inflight_pc <= pc;
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push)
            queue_mem[wr_ptr] <= '{word: imem_rdata, pc: inflight_pc};
    end

`ifdef FETCH_HALT_EN
    always_ff @(posedge clk) begin
        if (rst || redirect)
            halt_q <= 1'b0;
        else if (push && (imem_rdata == '1))
            halt_q <= 1'b1;
    end
`else
    assign halt_q = 1'b0;
`endif

    assign halted = halt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 1-cycle-latency instruction memory model.
// Covers reset, streaming, queue-full back-pressure, redirect flush, PC wrap, reset mid-stream, halt word.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        halted;

    logic [15:0] mem [65536];
    logic        mem_valid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        stray_valid = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          n_req;
    logic [15:0] addr_log [4];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data and valid appear one cycle after the request.
    always @(posedge clk) begin
        mem_valid <= imem_req;
        mem_rdata <= mem[imem_addr];
    end
    assign imem_valid = mem_valid | stray_valid;
    assign imem_rdata = mem_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        stray_valid = 1'b0;
        next();
        next();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++)
            mem[i] = {4'hA, 12'(i)};
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;

        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;

        // Reset state
        next();
        next();
        settle();
        chk("rst_req",      32'(imem_req),    32'd0);
        chk("rst_valid",    32'(instr_valid), 32'd0);
        chk("rst_instr",    32'(instr),       32'h0);
        chk("rst_instr_pc", 32'(instr_pc),    32'h0);
        chk("rst_halted",   32'(halted),      32'd0);
        chk("rst_addr",     32'(imem_addr),   32'h0);

        // Streaming from reset with decode always ready
        do_reset();
        instr_ready = 1'b1;
        settle();
        chk("s_c0_req",   32'(imem_req),    32'd1);
        chk("s_c0_addr",  32'(imem_addr),   32'h0);
        chk("s_c0_valid", 32'(instr_valid), 32'd0);
        next(); settle();
        chk("s_c1_addr",  32'(imem_addr),   32'h1);
        chk("s_c1_valid", 32'(instr_valid), 32'd0);
        next(); settle();
        chk("s_c2_valid", 32'(instr_valid), 32'd1);
        chk("s_c2_instr", 32'(instr),       32'h1111);
        chk("s_c2_pc",    32'(instr_pc),    32'h0);
        next(); settle();
        chk("s_c3_instr", 32'(instr),       32'h2222);
        chk("s_c3_pc",    32'(instr_pc),    32'h1);
        next(); settle();
        chk("s_c4_instr", 32'(instr),       32'h3333);
        chk("s_c4_pc",    32'(instr_pc),    32'h2);

        // Queue fills with decode stalled, then drains
        do_reset();
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (imem_req) begin
                if (n_req < 4)
                    addr_log[n_req] = imem_addr;
                n_req++;
            end
            next();
        end
        chk("full_nreq", 32'(n_req), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("full_addr", 32'(addr_log[i]), 32'(i));
        instr_ready = 1'b1;
        settle();
        chk("full_req_hold", 32'(imem_req), 32'd0);
        chk("full_head_pc",  32'(instr_pc), 32'h0);
        next(); settle();
        chk("drain_req",  32'(imem_req),  32'd1);
        chk("drain_addr", 32'(imem_addr), 32'h4);
        chk("drain_pc1",  32'(instr_pc),  32'h1);
        next(); settle();
        chk("drain_pc2",  32'(instr_pc),  32'h2);
        next(); settle();
        chk("drain_pc3",  32'(instr_pc),  32'h3);
        next(); settle();
        chk("drain_pc4",   32'(instr_pc), 32'h4);
        chk("drain_instr4", 32'(instr),   32'hA004);

        // Redirect with 3 queued entries and one response in flight
        do_reset();
        next(); next(); next(); next();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        settle();
        chk("rd_t0_req",   32'(imem_req),    32'd0);
        chk("rd_t0_valid", 32'(instr_valid), 32'd0);
        next();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        settle();
        chk("rd_t1_req",   32'(imem_req),    32'd1);
        chk("rd_t1_addr",  32'(imem_addr),   32'h40);
        chk("rd_t1_valid", 32'(instr_valid), 32'd0);
        next(); settle();
        chk("rd_t2_valid", 32'(instr_valid), 32'd0);
        chk("rd_t2_addr",  32'(imem_addr),   32'h41);
        next(); settle();
        chk("rd_t3_valid", 32'(instr_valid), 32'd1);
        chk("rd_t3_pc",    32'(instr_pc),    32'h40);
        chk("rd_t3_instr", 32'(instr),       32'hA040);
        next(); settle();
        chk("rd_t4_pc",    32'(instr_pc),    32'h41);

        // Back-to-back redirects, last wins; PC wraps past 0xFFFF
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        settle();
        chk("wrap_r0_req", 32'(imem_req), 32'd0);
        next();
        redirect_pc = 16'hFFFE;
        settle();
        chk("wrap_r1_req",   32'(imem_req),    32'd0);
        chk("wrap_r1_valid", 32'(instr_valid), 32'd0);
        next();
        redirect = 1'b0;
        settle();
        chk("wrap_addr0", 32'(imem_addr), 32'hFFFE);
        next(); settle();
        chk("wrap_addr1", 32'(imem_addr), 32'hFFFF);
        next(); settle();
        chk("wrap_addr2", 32'(imem_addr), 32'h0000);
        chk("wrap_pc0",   32'(instr_pc),  32'hFFFE);
        chk("wrap_ins0",  32'(instr),     32'hAFFE);
        next(); settle();
        chk("wrap_pc1",   32'(instr_pc),  32'hFFFF);
        next(); settle();
        chk("wrap_pc2",   32'(instr_pc),  32'h0000);
        chk("wrap_ins2",  32'(instr),     32'h1111);

        // Reset mid-stream with a partly full queue, then a stray response
        instr_ready = 1'b0;
        next(); next(); next();
        rst = 1'b1;
        settle();
        chk("mr_rst_req", 32'(imem_req), 32'd0);
        next();
        rst         = 1'b0;
        stray_valid = 1'b1;
        settle();
        chk("mr_valid",  32'(instr_valid), 32'd0);
        chk("mr_instr",  32'(instr),       32'h0);
        chk("mr_pc",     32'(instr_pc),    32'h0);
        chk("mr_addr",   32'(imem_addr),   32'h0);
        chk("mr_req",    32'(imem_req),    32'd1);
        next();
        stray_valid = 1'b0;
        settle();
        chk("mr_stray_dropped", 32'(instr_valid), 32'd0);
        next(); settle();
        chk("mr_first_valid", 32'(instr_valid), 32'd1);
        chk("mr_first_pc",    32'(instr_pc),    32'h0);

        // All-ones word at address 2
        mem[2] = 16'hFFFF;
        do_reset();
        instr_ready = 1'b1;
        next(); next(); settle();
        chk("h_c2_instr", 32'(instr), 32'h1111);
        next(); settle();
        chk("h_c3_instr",  32'(instr),    32'h2222);
        chk("h_c3_halted", 32'(halted),   32'd0);
        chk("h_c3_addr",   32'(imem_addr), 32'h3);
        next(); settle();
        chk("h_c4_instr", 32'(instr),    32'hFFFF);
        chk("h_c4_pc",    32'(instr_pc), 32'h2);
`ifdef FETCH_HALT_EN
        chk("h_c4_halted", 32'(halted),   32'd1);
        chk("h_c4_req",    32'(imem_req), 32'd0);
        next(); settle();
        chk("h_c5_req",   32'(imem_req),    32'd0);
        chk("h_c5_pc",    32'(instr_pc),    32'h3);
        next(); settle();
        chk("h_c6_req",   32'(imem_req),    32'd0);
        chk("h_c6_valid", 32'(instr_valid), 32'd0);
        next();
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        settle();
        chk("h_c7_halted", 32'(halted), 32'd1);
        next();
        redirect = 1'b0;
        settle();
        chk("h_c8_halted", 32'(halted),    32'd0);
        chk("h_c8_req",    32'(imem_req),  32'd1);
        chk("h_c8_addr",   32'(imem_addr), 32'h10);
`else
        chk("h_c4_halted", 32'(halted),    32'd0);
        chk("h_c4_req",    32'(imem_req),  32'd1);
        chk("h_c4_addr",   32'(imem_addr), 32'h4);
        next(); settle();
        chk("h_c5_pc",     32'(instr_pc),  32'h3);
        chk("h_c5_req",    32'(imem_req),  32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
